hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard / stall / flush controller.
//
// Purpose
//   Turns decode, memory and mult/div hazard requests into per-stage stall
//   and flush controls plus a PC redirect select. The outputs follow a fixed
//   priority: exception > data-memory wait > busy mult/div > instruction-fetch
//   wait > load-use > taken branch. A small FSM tracks a multi-cycle mult/div
//   and the single cycle after an exception.
//
// Handshake
//   No valid/ready handshakes. All inputs are level requests sampled every
//   cycle. All outputs except stall_cycles and state_o are combinational.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   load_use            : decode load-use hazard
//   branch_taken        : decode resolved a taken branch/jump
//   mdu_start           : mult/div instruction in execute this cycle
//   mdu_done            : mult/div result ready
//   imem_wait           : instruction fetch not complete
//   dmem_wait           : memory-stage data access not complete
//   exc_valid           : memory stage commits an exception or eret
//   stall_f/d/e/m       : hold the named pipeline register
//   flush_d/e/m/w       : load a bubble into the named pipeline register
//   redirect_sel[1:0]   : 0 sequential, 1 branch target, 2 exception vector
//   mdu_abort           : one-cycle kill of an in-flight mult/div
//   stall_cycles[31:0]  : count of cycles with stall_f=1 (wraps)
//   state_o[1:0]        : debug view of the FSM state (0 RUN, 1 MDU_BUSY, 2 EXC_FLUSH)
module hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_use,
  input  logic        branch_taken,
  input  logic        mdu_start,
  input  logic        mdu_done,
  input  logic        imem_wait,
  input  logic        dmem_wait,
  input  logic        exc_valid,
  output logic        stall_f,
  output logic        stall_d,
  output logic        stall_e,
  output logic        stall_m,
  output logic        flush_d,
  output logic        flush_e,
  output logic        flush_m,
  output logic        flush_w,
  output logic [1:0]  redirect_sel,
  output logic        mdu_abort,
  output logic [31:0] stall_cycles,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MDU_BUSY  = 2'd1,
    EXC_FLUSH = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;

  // Output decode, strictly prioritised.
  always_comb begin
    stall_f      = 1'b0;
    stall_d      = 1'b0;
    stall_e      = 1'b0;
    stall_m      = 1'b0;
    flush_d      = 1'b0;
    flush_e      = 1'b0;
    flush_m      = 1'b0;
    flush_w      = 1'b0;
    redirect_sel = 2'd0;
    mdu_abort    = 1'b0;
    if (reset) begin
      // Everything quiet while in reset.
    end else if (exc_valid) begin
      flush_d      = 1'b1;
      flush_e      = 1'b1;
      flush_m      = 1'b1;
      redirect_sel = 2'd2;
      // Kill the mult/div whether it is already running or starting now.
      mdu_abort    = (state_q == MDU_BUSY) || ((state_q == RUN) && mdu_start);
    end else if (dmem_wait) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if ((state_q == MDU_BUSY) && !mdu_done) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      flush_m = 1'b1;
    end else if (state_q == EXC_FLUSH) begin
      // The instruction fetched alongside the exception is wrong-path.
      flush_d = 1'b1;
    end else if (imem_wait) begin
      stall_f = 1'b1;
      flush_d = 1'b1;
    end else if (load_use) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end else if (branch_taken) begin
      // Not latched: a suppressed branch is simply re-presented by decode.
      redirect_sel = 2'd1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (exc_valid) begin
      state_d = EXC_FLUSH;
    end else begin
      unique case (state_q)
        RUN: begin
          // A stalled memory stage freezes execute, so the mult/div waits.
          if (!dmem_wait && mdu_start && !mdu_done) state_d = MDU_BUSY;
        end
        MDU_BUSY: begin
          // Done releases the FSM even if a dmem stall is applied this cycle.
          if (mdu_done) state_d = RUN;
        end
        EXC_FLUSH: state_d = RUN;
        default:   state_d = RUN;
      endcase
    end
  end

  assign stall_cycles_d = stall_f ? stall_cycles_q + 32'd1 : stall_cycles_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      stall_cycles_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed cycle-by-cycle stimulus with expected
// output vectors queued at drive time and compared once outputs settle.
module tb_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic        load_use, branch_taken, mdu_start, mdu_done;
  logic        imem_wait, dmem_wait, exc_valid;
  logic        stall_f, stall_d, stall_e, stall_m;
  logic        flush_d, flush_e, flush_m, flush_w;
  logic [1:0]  redirect_sel;
  logic        mdu_abort;
  logic [31:0] stall_cycles;
  logic [1:0]  state_o;

  int errors = 0;
  int checks = 0;

  logic [10:0] exp_q[$];
  logic [31:0] exp_cnt;

  // State codes
  localparam logic [1:0] S_RUN = 2'd0, S_BUSY = 2'd1, S_EXC = 2'd2;

  // Input vector bits: {reset, load_use, branch_taken, mdu_start, mdu_done, imem_wait, dmem_wait, exc_valid}
  localparam logic [7:0] I_NONE = 8'b0000_0000;
  localparam logic [7:0] I_RST  = 8'b1000_0000;
  localparam logic [7:0] I_LU   = 8'b0100_0000;
  localparam logic [7:0] I_BR   = 8'b0010_0000;
  localparam logic [7:0] I_MS   = 8'b0001_0000;
  localparam logic [7:0] I_MD   = 8'b0000_1000;
  localparam logic [7:0] I_IW   = 8'b0000_0100;
  localparam logic [7:0] I_DW   = 8'b0000_0010;
  localparam logic [7:0] I_EXC  = 8'b0000_0001;

  // Output vectors: {stall_f,d,e,m, flush_d,e,m,w, redirect_sel[1:0], mdu_abort}
  localparam logic [10:0] O_ZERO  = 11'b0000_0000_000;
  localparam logic [10:0] O_LU    = 11'b1100_0100_000;
  localparam logic [10:0] O_BUSY  = 11'b1110_0010_000;
  localparam logic [10:0] O_EXC   = 11'b0000_1110_100;
  localparam logic [10:0] O_EXCAB = 11'b0000_1110_101;
  localparam logic [10:0] O_EFL   = 11'b0000_1000_000;
  localparam logic [10:0] O_DMEM  = 11'b1111_0001_000;
  localparam logic [10:0] O_IMEM  = 11'b1000_1000_000;
  localparam logic [10:0] O_BR    = 11'b0000_0000_010;

  hazard_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .load_use     (load_use),
    .branch_taken (branch_taken),
    .mdu_start    (mdu_start),
    .mdu_done     (mdu_done),
    .imem_wait    (imem_wait),
    .dmem_wait    (dmem_wait),
    .exc_valid    (exc_valid),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .stall_e      (stall_e),
    .stall_m      (stall_m),
    .flush_d      (flush_d),
    .flush_e      (flush_e),
    .flush_m      (flush_m),
    .flush_w      (flush_w),
    .redirect_sel (redirect_sel),
    .mdu_abort    (mdu_abort),
    .stall_cycles (stall_cycles),
    .state_o      (state_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle: apply inputs at negedge, queue the expected outputs,
  // compare the settled outputs, then check state/counter after the edge.
  task automatic step(input string tag, input logic [7:0] in,
                      input logic [10:0] exp_out, input logic [1:0] exp_state);
    logic [10:0] got;
    logic [10:0] e;
    @(negedge clk);
    {reset, load_use, branch_taken, mdu_start, mdu_done, imem_wait, dmem_wait, exc_valid} = in;
    exp_q.push_back(exp_out);
    #1;
    got = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w,
           redirect_sel, mdu_abort};
    e = exp_q.pop_front();
    check_val({tag, ".out"}, {21'd0, got}, {21'd0, e});
    if (in[7]) exp_cnt = 32'd0;
    else if (exp_out[10]) exp_cnt = exp_cnt + 32'd1;
    @(posedge clk);
    #1;
    check_val({tag, ".state"}, {30'd0, state_o}, {30'd0, exp_state});
    check_val({tag, ".cnt"}, stall_cycles, exp_cnt);
  endtask

  initial begin
    {reset, load_use, branch_taken, mdu_start, mdu_done, imem_wait, dmem_wait, exc_valid} = '0;
    reset   = 1'b1;
    exp_cnt = 32'd0;

    // Reset with noisy inputs: outputs quiet, state RUN, counter 0
    step("rst", I_RST | I_LU | I_IW | I_DW | I_EXC, O_ZERO, S_RUN);
    step("idle", I_NONE, O_ZERO, S_RUN);

    // Load-use single cycle
    step("lu", I_LU, O_LU, S_RUN);
    check_val("lu.cnt1", stall_cycles, 32'd1);
    step("lu.after", I_NONE, O_ZERO, S_RUN);

    // Mult/div: start, 5 busy cycles, done
    step("mdu.rst", I_RST, O_ZERO, S_RUN);
    step("mdu.start", I_MS, O_ZERO, S_BUSY);
    for (int i = 0; i < 5; i++) step("mdu.busy", I_NONE, O_BUSY, S_BUSY);
    step("mdu.done", I_MD, O_ZERO, S_RUN);
    check_val("mdu.cnt5", stall_cycles, 32'd5);

    // mdu_start with mdu_done already high stays in RUN
    step("mdu.fast", I_MS | I_MD, O_ZERO, S_RUN);

    // Exception during MDU_BUSY
    step("exc.start", I_MS, O_ZERO, S_BUSY);
    step("exc.busy", I_NONE, O_BUSY, S_BUSY);
    step("exc.hit", I_EXC | I_IW | I_LU, O_EXCAB, S_EXC);
    step("exc.flush", I_NONE, O_EFL, S_RUN);
    step("exc.run", I_NONE, O_ZERO, S_RUN);

    // Exception with mdu_start in RUN also aborts
    step("exc.ms", I_EXC | I_MS, O_EXCAB, S_EXC);
    // Back-to-back exception from EXC_FLUSH: no abort, stays in EXC_FLUSH
    step("exc.again", I_EXC, O_EXC, S_EXC);
    step("exc.flush2", I_NONE, O_EFL, S_RUN);

    // dmem_wait beats branch and load-use; branch honoured after release
    for (int i = 0; i < 3; i++) step("dmem", I_DW | I_BR | I_LU, O_DMEM, S_RUN);
    step("br.after", I_BR, O_BR, S_RUN);

    // dmem_wait coinciding with mdu_done: dmem stall, leave MDU_BUSY
    step("md.start", I_MS, O_ZERO, S_BUSY);
    step("md.dw", I_MD | I_DW, O_DMEM, S_RUN);

    // dmem_wait in MDU_BUSY without done: dmem stall, stay busy
    step("md.start2", I_MS, O_ZERO, S_BUSY);
    step("md.dw2", I_DW, O_DMEM, S_BUSY);
    step("md.done2", I_MD, O_ZERO, S_RUN);

    // imem_wait alone, imem_wait beats load-use and branch
    step("imem", I_IW, O_IMEM, S_RUN);
    step("imem.br", I_IW | I_BR | I_LU, O_IMEM, S_RUN);
    // load-use suppresses the branch redirect
    step("lu.br", I_LU | I_BR, O_LU, S_RUN);
    step("br", I_BR, O_BR, S_RUN);

    // Randomised idle/branch cycles with nothing else active
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 1) == 1) step("rnd.br", I_BR, O_BR, S_RUN);
      else step("rnd.idle", I_NONE, O_ZERO, S_RUN);
    end

    // Counter wrap: preset to all-ones, then one imem stall cycle
    @(negedge clk);
    force dut.stall_cycles_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cycles_q;
    #1;
    exp_cnt = 32'hFFFF_FFFF;
    check_val("wrap.preset", stall_cycles, 32'hFFFF_FFFF);
    step("wrap", I_IW, O_IMEM, S_RUN);
    check_val("wrap.zero", stall_cycles, 32'd0);

    // Reset in the middle of MDU_BUSY
    step("rb.start", I_MS, O_ZERO, S_BUSY);
    step("rb.busy", I_NONE, O_BUSY, S_BUSY);
    step("rb.rst", I_RST | I_IW, O_ZERO, S_RUN);
    step("rb.after", I_NONE, O_ZERO, S_RUN);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
